lc4_seq_divider: RTL and testbench
==================================

LC4_SEQ_DIVIDER -- requirements
Module: lc4_seq_divider

Interface
REQ-001 Port clk, input, 1, sole clock; all state SHALL update on its rising edge.
REQ-002 Port rst, input, 1, asynchronous active-high reset.
REQ-003 Port i_valid, input, 1, operands on i_dividend/i_divisor are offered.
REQ-004 Port i_ready, output, 1, block can accept a new operation.
REQ-005 Port i_dividend, input, 16, unsigned dividend.
REQ-006 Port i_divisor, input, 16, unsigned divisor.
REQ-007 Port o_valid, output, 1, result available.
REQ-008 Port o_ready, input, 1, consumer accepts the result.
REQ-009 Port o_quotient, output, 16, unsigned quotient.
REQ-010 Port o_remainder, output, 16, unsigned remainder.
REQ-011 Port o_busy, output, 1, iteration in progress (state RUN).

Function
REQ-012 FSM states SHALL be IDLE, RUN and DONE, with a 4-bit iteration counter.
REQ-013 IDLE: i_ready=1; on an edge with i_valid=1, latch operands, clear the partial remainder, set counter=15, latch div_zero=(i_divisor==0), go to RUN.
REQ-014 i_ready SHALL be 1 only in IDLE; i_valid in RUN/DONE is ignored and not queued.
REQ-015 RUN: each edge performs one restoring step, MSB first: shift {rem, next dividend bit}, 17-bit trial subtract of the divisor; no borrow -> rem=diff, quotient bit=1; borrow -> rem unchanged, bit=0.
REQ-016 RUN: decrement the counter each edge; the edge with counter=0 performs the final step and enters DONE.
REQ-017 Latency SHALL be fixed: accept on edge k -> o_valid=1 after edge k+16, for every operand value including a zero divisor.
REQ-018 DONE: o_valid=1; o_quotient/o_remainder SHALL equal floor(dividend/divisor) and dividend mod divisor.
REQ-019 Zero divisor: o_quotient=0x0000 and o_remainder=0x0000 (LC4 DIV/MOD semantics), overriding the datapath.
REQ-020 DONE with o_ready=0: o_valid, o_quotient and o_remainder SHALL be held stable, with no timeout.
REQ-021 DONE with o_ready=1: the result is consumed on that edge -> IDLE; a new i_valid is not accepted on the same edge.
REQ-022 o_quotient and o_remainder SHALL read 0x0000 whenever o_valid=0.
REQ-023 o_busy SHALL be 1 exactly in RUN; i_ready, o_valid and o_busy are mutually exclusive.
REQ-024 Operand inputs need only be stable on the accepting edge; later changes SHALL NOT affect the result.
REQ-025 The trial subtract SHALL be 17 bits wide, so a shifted remainder up to 0x1FFFE is handled without overflow.

Reset
REQ-026 rst=1 SHALL immediately, without a clock edge, force IDLE, i_ready=1, o_valid=0, o_busy=0, o_quotient=0, o_remainder=0, counter=0 and clear internal registers.
REQ-027 rst asserted during RUN or DONE SHALL discard the in-flight operation with no later o_valid for it.
REQ-028 After rst deasserts, the first rising edge with i_valid=1 SHALL be accepted normally.

Verification
REQ-029 100/7, accept edge k, o_ready=1 -> o_valid first high after edge k+16, q=14, r=2, IDLE one edge later.
REQ-030 0xFFFF/0x0001 -> q=0xFFFF, r=0x0000; 5/9 -> q=0, r=5; 0xFFFF/0xFFFF -> q=1, r=0.
REQ-031 0x1234/0 -> q=0x0000, r=0x0000 at the same 16-cycle latency.
REQ-032 1000/33 with o_ready=0 for 10 cycles after o_valid -> q=30, r=10 held constant, i_ready=0 throughout, i_valid pulses ignored; o_ready=1 -> IDLE.
REQ-033 rst pulsed mid-cycle 8 cycles into RUN -> outputs zero, IDLE at once, no o_valid; next op 50/5 -> q=10, r=0.
REQ-034 Randomised back-to-back ops (>=1000) against a reference model -> all results match and latency is always 16.

Source files
------------

// File: rtl/lc4_seq_divider.sv
// rtl/lc4_seq_divider.sv - 16-bit unsigned restoring divider, one quotient bit per clock
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-high reset
//   i_valid      operands offered on i_dividend / i_divisor
//   i_ready      block is idle and will accept an operation
//   i_dividend   16-bit unsigned dividend
//   i_divisor    16-bit unsigned divisor
//   o_valid      result available
//   o_ready      consumer accepts the result
//   o_quotient   quotient, zero whenever o_valid is low or the divisor was zero
//   o_remainder  remainder, zero whenever o_valid is low or the divisor was zero
//   o_busy       iteration in progress
module lc4_seq_divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    output logic        i_ready,
    input  logic [15:0] i_dividend,
    input  logic [15:0] i_divisor,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [15:0] o_quotient,
    output logic [15:0] o_remainder,
    output logic        o_busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [3:0]  count;
    // quo starts as the dividend; each step shifts out its MSB into the
    // partial remainder and shifts the new quotient bit in at the bottom.
    logic [15:0] quo;
    logic [15:0] dsr;
    logic [15:0] rem;
    logic        div_zero;

    logic [16:0] shifted;
    logic [16:0] trial;
    logic        borrow;

    always_comb begin
        shifted = {rem, quo[15]};
        trial   = shifted - {1'b0, dsr};
        // With a non-zero divisor rem < dsr holds, so shifted < 2*dsr. A
        // successful subtract therefore leaves a result below 2^16, while a
        // borrow wraps to at least 2^16: bit 16 is exactly the borrow flag.
        // A zero divisor breaks the invariant, but its result is masked.
        borrow  = trial[16];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= 4'd0;
            quo      <= 16'd0;
            dsr      <= 16'd0;
            rem      <= 16'd0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        quo      <= i_dividend;
                        dsr      <= i_divisor;
                        rem      <= 16'd0;
                        count    <= 4'd15;
                        div_zero <= (i_divisor == 16'd0);
                        state    <= RUN;
                    end
                end
                RUN: begin
                    quo   <= {quo[14:0], ~borrow};
                    rem   <= borrow ? shifted[15:0] : trial[15:0];
                    count <= count - 4'd1;
                    if (count == 4'd0) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (o_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        i_ready     = (state == IDLE);
        o_busy      = (state == RUN);
        o_valid     = (state == DONE);
        o_quotient  = (o_valid && !div_zero) ? quo : 16'd0;
        o_remainder = (o_valid && !div_zero) ? rem : 16'd0;
    end

endmodule

// File: tb/tb_lc4_seq_divider.sv
// tb/tb_lc4_seq_divider.sv - self-checking bench for lc4_seq_divider
module tb_lc4_seq_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_ready;
    logic [15:0] i_dividend;
    logic [15:0] i_divisor;
    logic        o_valid;
    logic        o_ready;
    logic [15:0] o_quotient;
    logic [15:0] o_remainder;
    logic        o_busy;

    lc4_seq_divider dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid     (i_valid),
        .i_ready     (i_ready),
        .i_dividend  (i_dividend),
        .i_divisor   (i_divisor),
        .o_valid     (o_valid),
        .o_ready     (o_ready),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder),
        .o_busy      (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        int          hold;
    } vec_t;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
    } res_t;

    res_t sb[$];
    vec_t vecs[9];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one operation, measure latency, compare against the scoreboard,
    // optionally stall the consumer for 'hold' cycles, then retire it.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input int hold);
        int   t;
        int   lat;
        res_t exp_res;
        t = 0;
        while (!i_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("ready_wait", i_ready, 1);
        i_dividend = a;
        i_divisor  = b;
        i_valid    = 1'b1;
        o_ready    = (hold == 0);
        sb.push_back('{q: eq, r: er});
        @(posedge clk); #1;
        i_valid    = 1'b0;
        i_dividend = 16'($urandom);
        i_divisor  = 16'($urandom);
        check("busy_after_accept", {i_ready, o_busy, o_valid}, 3'b010);
        lat = 0;
        while (!o_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, 16);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
            return;
        end
        exp_res = sb.pop_front();
        if (!o_valid) return;
        check("quotient", o_quotient, exp_res.q);
        check("remainder", o_remainder, exp_res.r);
        check("done_flags", {i_ready, o_busy}, 2'b00);
        for (int h = 0; h < hold; h++) begin
            i_valid    = h[0];
            i_dividend = 16'($urandom);
            i_divisor  = 16'($urandom);
            @(posedge clk); #1;
            check("hold_valid", {o_valid, i_ready, o_busy}, 3'b100);
            check("hold_quotient", o_quotient, exp_res.q);
            check("hold_remainder", o_remainder, exp_res.r);
        end
        // offer a new operation on the consuming edge: it must not be taken
        i_valid = (hold != 0);
        o_ready = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        check("retire_idle", {i_ready, o_valid, o_busy}, 3'b100);
        check("idle_outputs", {o_quotient, o_remainder}, 32'd0);
    endtask

    initial begin
        int   seen;
        logic [15:0] a;
        logic [15:0] b;

        vecs[0] = '{a: 16'd100,    b: 16'd7,      q: 16'd14,     r: 16'd2,      hold: 0};
        vecs[1] = '{a: 16'hFFFF,   b: 16'h0001,   q: 16'hFFFF,   r: 16'h0000,   hold: 0};
        vecs[2] = '{a: 16'd5,      b: 16'd9,      q: 16'd0,      r: 16'd5,      hold: 0};
        vecs[3] = '{a: 16'hFFFF,   b: 16'hFFFF,   q: 16'd1,      r: 16'd0,      hold: 0};
        vecs[4] = '{a: 16'h1234,   b: 16'h0000,   q: 16'h0000,   r: 16'h0000,   hold: 0};
        vecs[5] = '{a: 16'd1000,   b: 16'd33,     q: 16'd30,     r: 16'd10,     hold: 10};
        vecs[6] = '{a: 16'd0,      b: 16'd5,      q: 16'd0,      r: 16'd0,      hold: 0};
        vecs[7] = '{a: 16'hFFFE,   b: 16'h8001,   q: 16'd1,      r: 16'h7FFD,   hold: 0};
        vecs[8] = '{a: 16'hFFFF,   b: 16'h00FF,   q: 16'h0101,   r: 16'h0000,   hold: 3};

        rst        = 1'b1;
        i_valid    = 1'b0;
        o_ready    = 1'b1;
        i_dividend = 16'd0;
        i_divisor  = 16'd0;
        #2;
        check("reset_flags", {i_ready, o_valid, o_busy}, 3'b100);
        check("reset_outputs", {o_quotient, o_remainder}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].hold);
        end

        // reset mid-RUN discards the operation immediately
        i_dividend = 16'd1000;
        i_divisor  = 16'd33;
        i_valid    = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrun_reset_flags", {i_ready, o_valid, o_busy}, 3'b100);
        check("midrun_reset_outputs", {o_quotient, o_remainder}, 32'd0);
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (o_valid) seen++;
        end
        check("no_valid_after_reset", seen, 0);
        run_op(16'd50, 16'd5, 16'd10, 16'd0, 0);

        // randomised back-to-back operations against a reference model
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            case ($urandom_range(0, 7))
                0:       b = 16'd0;
                1, 2:    b = 16'($urandom_range(1, 15));
                3:       b = 16'hFFFF - 16'($urandom_range(0, 3));
                default: b = 16'($urandom);
            endcase
            if (b == 16'd0) run_op(a, b, 16'd0, 16'd0, $urandom_range(0, 1));
            else            run_op(a, b, a / b, a % b, $urandom_range(0, 1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
